// File: rtl/subtractor_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined wide subtractor.
package subtractor_pkg;

  localparam int unsigned WIDTH_DEF = 91;
  localparam int unsigned SEG_DEF   = 32;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return (width + seg - 1) / seg;
  endfunction

  // Only the top segment can be narrower than seg.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned seg,
                                            input int unsigned k);
    return (k == nseg(width, seg) - 1) ? width - k * seg : seg;
  endfunction

endpackage

// File: rtl/subtractor_seg.sv
// Combinational W-bit subtract-with-borrow slice.
module subtractor_seg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_seg,
  input  logic [W-1:0] b_seg,
  input  logic         borrow_in,
  output logic [W-1:0] d_seg,
  output logic         borrow_out
);

  logic [W:0] full;

  // One extra bit: a negative result sets it, which is exactly the borrow.
  assign full       = {1'b0, a_seg} - {1'b0, b_seg} - {{W{1'b0}}, borrow_in};
  assign d_seg      = full[W-1:0];
  assign borrow_out = full[W];

endmodule

// File: rtl/subtractor_pipe.sv
// Pipelined wide subtractor: input register plus one borrow-segment stage per SEG bits,
// with valid/ready handshakes at both ends.
module subtractor_pipe
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   diff,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG);

  // valid_q[0] is the input register, valid_q[k] the k-th segment stage.
  logic [NSEG:0]      valid_q;
  logic [WIDTH-1:0]   a_q [NSEG];
  logic [WIDTH-1:0]   b_q [NSEG];
  // res_q[k]/borrow_q[k] hold the result after segment k has been resolved.
  logic [WIDTH-1:0]   res_q [NSEG];
  logic [NSEG-1:0]    borrow_q;
  logic [WIDTH-1:0]   res_nxt [NSEG];
  logic [NSEG-1:0]    borrow_nxt;
  logic               adv;

  assign adv       = !valid_q[NSEG] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[NSEG];
  assign diff      = {borrow_q[NSEG-1], res_q[NSEG-1]};

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int unsigned Lo   = k * SEG;
    localparam int unsigned SegW = seg_width(WIDTH, SEG, k);

    logic             bin;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt;
    logic [SegW-1:0]  seg_d;
    logic             seg_bo;

    if (k == 0) begin : g_first
      assign bin  = 1'b0;
      assign base = '0;
    end else begin : g_rest
      assign bin  = borrow_q[k-1];
      assign base = res_q[k-1];
    end

    subtractor_seg #(
      .W(SegW)
    ) u_seg (
      .a_seg     (a_q[k][Lo +: SegW]),
      .b_seg     (b_q[k][Lo +: SegW]),
      .borrow_in (bin),
      .d_seg     (seg_d),
      .borrow_out(seg_bo)
    );

    always_comb begin
      nxt             = base;
      nxt[Lo +: SegW] = seg_d;
    end

    assign res_nxt[k]    = nxt;
    assign borrow_nxt[k] = seg_bo;
  end

  // Data registers only load behind a valid token so diff holds through bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      borrow_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= {valid_q[NSEG-1:0], in_valid};
      if (in_valid) begin
        a_q[0] <= a;
        b_q[0] <= b;
      end
      for (int k = 1; k < NSEG; k++) begin
        if (valid_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
      for (int k = 0; k < NSEG; k++) begin
        if (valid_q[k]) begin
          res_q[k]    <= res_nxt[k];
          borrow_q[k] <= borrow_nxt[k];
        end
      end
    end
  end

endmodule
